// File: rtl/slot_arbiter.sv
// Round-robin, time-slotted arbiter: four requesters share one resource, each grant
// lasts at most SLOTLEN cycles and is followed by a one-cycle guard gap.
module slot_arbiter #(
  parameter int unsigned SLOTLEN = 4
) (
  input  logic       IPTCLK,
  input  logic       IPTRSTN,
  input  logic [3:0] REQ,
  input  logic [3:0] DONE,
  output logic [3:0] GNT,
  output logic [1:0] OWNER,
  output logic [2:0] SLOT,
  output logic       BUSY
);

  localparam int unsigned SLOT_W   = 3;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTLEN - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        r_last;
  logic [3:0]        r_gnt;
  logic [1:0]        r_owner;
  logic [SLOT_W-1:0] r_slot;
  logic              r_busy;

  logic [1:0]        w_state_nxt;
  logic [1:0]        w_last_nxt;
  logic [3:0]        w_gnt_nxt;
  logic [1:0]        w_owner_nxt;
  logic [SLOT_W-1:0] w_slot_nxt;
  logic              w_win_vld;
  logic [1:0]        w_win_idx;
  logic              w_release;

  // Rotating priority search starting just after the last grantee
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      if (!w_win_vld && REQ[2'(r_last + 2'(i))]) begin
        w_win_vld = 1'b1;
        w_win_idx = 2'(r_last + 2'(i));
      end
    end
  end

  assign w_release = (r_slot == SLOT_LAST) || DONE[r_owner] || !REQ[r_owner];

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_gnt_nxt   = 4'b0000;
    w_owner_nxt = r_owner;
    w_slot_nxt  = '0;
    case (r_state)
      ST_IDLE, ST_GAP: begin
        if (w_win_vld) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = 4'(1) << w_win_idx;
          w_owner_nxt = w_win_idx;
          w_last_nxt  = w_win_idx;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_state_nxt = ST_GAP;
        end else begin
          w_gnt_nxt  = r_gnt;
          w_slot_nxt = r_slot + SLOT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge IPTCLK) begin
    if (!IPTRSTN) begin
      r_state <= ST_IDLE;
      r_last  <= 2'd3;
      r_gnt   <= 4'b0000;
      r_owner <= 2'd0;
      r_slot  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_gnt   <= w_gnt_nxt;
      r_owner <= w_owner_nxt;
      r_slot  <= w_slot_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  assign GNT   = r_gnt;
  assign OWNER = r_owner;
  assign SLOT  = r_slot;
  assign BUSY  = r_busy;

endmodule

// File: tb/tb_slot_arbiter.sv
// Directed bench for slot_arbiter: three instances (SLOTLEN 4, 2, 8) share stimulus.
module tb_slot_arbiter;

  logic       clk;
  logic       rstn;
  logic [3:0] req;
  logic [3:0] done;

  logic [3:0] g4, g2, g8;
  logic [1:0] o4, o2, o8;
  logic [2:0] s4, s2, s8;
  logic       b4, b2, b8;

  int n_pass;
  int n_total;

  slot_arbiter #(.SLOTLEN(4)) u4 (.IPTCLK(clk), .IPTRSTN(rstn), .REQ(req), .DONE(done),
                                  .GNT(g4), .OWNER(o4), .SLOT(s4), .BUSY(b4));
  slot_arbiter #(.SLOTLEN(2)) u2 (.IPTCLK(clk), .IPTRSTN(rstn), .REQ(req), .DONE(done),
                                  .GNT(g2), .OWNER(o2), .SLOT(s2), .BUSY(b2));
  slot_arbiter #(.SLOTLEN(8)) u8 (.IPTCLK(clk), .IPTRSTN(rstn), .REQ(req), .DONE(done),
                                  .GNT(g8), .OWNER(o8), .SLOT(s8), .BUSY(b8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    req  = 4'b0000;
    done = 4'b0000;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req  = 4'b1111;
    done = 4'b0000;
    tick();
    tick();
    n_total++;
    if ({g4, o4, s4, b4} !== {4'b0000, 2'd0, 3'd0, 1'b0})
      $display("FAIL reset_u4: got gnt=%b own=%0d slot=%0d busy=%b want 0000/0/0/0", g4, o4, s4, b4);
    else n_pass++;
    n_total++;
    if ({g8, o8, s8, b8} !== {4'b0000, 2'd0, 3'd0, 1'b0})
      $display("FAIL reset_u8: got gnt=%b own=%0d slot=%0d busy=%b want 0000/0/0/0", g8, o8, s8, b8);
    else n_pass++;
    rstn = 1'b1;
    tick();
    n_total++;
    if ({g4, o4, s4, b4} !== {4'b0001, 2'd0, 3'd0, 1'b1})
      $display("FAIL first_grant: got gnt=%b own=%0d slot=%0d busy=%b want 0001/0/0/1", g4, o4, s4, b4);
    else n_pass++;
  endtask

  task automatic test_single();
    apply_reset();
    req = 4'b0100;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if ({g4, o4, s4, b4} !== {4'b0100, 2'd2, 3'(i), 1'b1})
        $display("FAIL single_slot%0d: got gnt=%b own=%0d slot=%0d busy=%b want 0100/2/%0d/1", i, g4, o4, s4, b4, i);
      else n_pass++;
      tick();
    end
    n_total++;
    if ({g4, s4, b4} !== {4'b0000, 3'd0, 1'b1})
      $display("FAIL single_gap: got gnt=%b slot=%0d busy=%b want 0000/0/1", g4, s4, b4);
    else n_pass++;
    tick();
    n_total++;
    if ({g4, o4, s4} !== {4'b0100, 2'd2, 3'd0})
      $display("FAIL single_regrant: got gnt=%b own=%0d slot=%0d want 0100/2/0", g4, o4, s4);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [1:0] exp_o;
    apply_reset();
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp_o = 2'(k % 4);
      exp_g = 4'b0001 << exp_o;
      for (int s = 0; s < 2; s++) begin
        n_total++;
        if ({g2, o2, s2, b2} !== {exp_g, exp_o, 3'(s), 1'b1})
          $display("FAIL rr_grant%0d_slot%0d: got gnt=%b own=%0d slot=%0d busy=%b want %b/%0d/%0d/1",
                   k, s, g2, o2, s2, b2, exp_g, exp_o, s);
        else n_pass++;
        tick();
      end
      if (k < 4) begin
        n_total++;
        if ({g2, b2} !== {4'b0000, 1'b1})
          $display("FAIL rr_gap%0d: got gnt=%b busy=%b want 0000/1", k, g2, b2);
        else n_pass++;
        tick();
      end
    end
  endtask

  task automatic test_early_release();
    apply_reset();
    req = 4'b0010;
    tick();
    tick();
    done = 4'b1000;
    tick();
    done = 4'b0000;
    n_total++;
    if ({g8, o8, s8} !== {4'b0010, 2'd1, 3'd2})
      $display("FAIL nonowner_done: got gnt=%b own=%0d slot=%0d want 0010/1/2", g8, o8, s8);
    else n_pass++;
    done = 4'b0010;
    tick();
    done = 4'b0000;
    n_total++;
    if ({g8, s8, b8} !== {4'b0000, 3'd0, 1'b1})
      $display("FAIL done_release: got gnt=%b slot=%0d busy=%b want 0000/0/1", g8, s8, b8);
    else n_pass++;
    tick();
    n_total++;
    if ({g8, s8} !== {4'b0010, 3'd0})
      $display("FAIL done_regrant: got gnt=%b slot=%0d want 0010/0", g8, s8);
    else n_pass++;
    for (int i = 0; i < 7; i++) tick();
    n_total++;
    if ({g8, s8} !== {4'b0010, 3'd7})
      $display("FAIL slot_max8: got gnt=%b slot=%0d want 0010/7", g8, s8);
    else n_pass++;
    done = 4'b0010;
    tick();
    done = 4'b0000;
    n_total++;
    if ({g8, s8, b8} !== {4'b0000, 3'd0, 1'b1})
      $display("FAIL expiry_done_gap: got gnt=%b slot=%0d busy=%b want 0000/0/1", g8, s8, b8);
    else n_pass++;
    tick();
    n_total++;
    if ({g8, s8} !== {4'b0010, 3'd0})
      $display("FAIL single_gap_only: got gnt=%b slot=%0d want 0010/0", g8, s8);
    else n_pass++;
  endtask

  task automatic test_withdraw();
    apply_reset();
    req = 4'b0100;
    tick();
    tick();
    n_total++;
    if ({g4, o4, s4} !== {4'b0100, 2'd2, 3'd1})
      $display("FAIL wd_slot1: got gnt=%b own=%0d slot=%0d want 0100/2/1", g4, o4, s4);
    else n_pass++;
    req = 4'b0000;
    tick();
    n_total++;
    if ({g4, b4} !== {4'b0000, 1'b1})
      $display("FAIL wd_gap: got gnt=%b busy=%b want 0000/1", g4, b4);
    else n_pass++;
    tick();
    n_total++;
    if ({g4, o4, s4, b4} !== {4'b0000, 2'd2, 3'd0, 1'b0})
      $display("FAIL wd_idle: got gnt=%b own=%0d slot=%0d busy=%b want 0000/2/0/0", g4, o4, s4, b4);
    else n_pass++;
    req = 4'b0001;
    tick();
    n_total++;
    if ({g4, o4, b4} !== {4'b0001, 2'd0, 1'b1})
      $display("FAIL wd_next: got gnt=%b own=%0d busy=%b want 0001/0/1", g4, o4, b4);
    else n_pass++;
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    req = 4'b1000;
    tick();
    tick();
    tick();
    tick();
    n_total++;
    if ({g4, o4, s4} !== {4'b1000, 2'd3, 3'd3})
      $display("FAIL rmg_slot3: got gnt=%b own=%0d slot=%0d want 1000/3/3", g4, o4, s4);
    else n_pass++;
    rstn = 1'b0;
    tick();
    n_total++;
    if ({g4, o4, s4, b4} !== {4'b0000, 2'd0, 3'd0, 1'b0})
      $display("FAIL rmg_reset: got gnt=%b own=%0d slot=%0d busy=%b want 0000/0/0/0", g4, o4, s4, b4);
    else n_pass++;
    rstn = 1'b1;
    tick();
    n_total++;
    if ({g4, o4, s4} !== {4'b1000, 2'd3, 3'd0})
      $display("FAIL rmg_regrant: got gnt=%b own=%0d slot=%0d want 1000/3/0", g4, o4, s4);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rstn = 1'b0;
    req  = 4'b0000;
    done = 4'b0000;
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_withdraw();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/slot_arbiter.md
# slot_arbiter

Round-robin, time-slotted arbiter that shares one divided-clock resource (the 3-bit binary counter/divider chain) among four requesters. Each requester holds a one-hot grant for at most SLOTLEN clock cycles. A one-cycle guard gap separates consecutive grants. An internal 3-bit slot counter times the slots and is exported for the granted user.

## Interface
- SLOTLEN, default 4: maximum grant length in IPTCLK cycles; legal range 1..8.
- IPTCLK  input  1  system clock; all state updates on its rising edge.
- IPTRSTN  input  1  reset, synchronous, active-low.
- REQ  input  4  request lines, one per requester, level-sensitive.
- DONE  input  4  early-release strobe; only DONE[OWNER] is honoured, and only while GNT is nonzero.
- GNT  output  4  one-hot grant, registered; all zero when no grant is active.
- OWNER  output  2  index of the current or most recent grantee.
- SLOT  output  3  cycle index within the current grant, 0..SLOTLEN-1; 0 outside a grant.
- BUSY  output  1  high in GRANT or GAP state.

## Operation
- Internal state:
  - FSM state: IDLE, GRANT or GAP.
  - 2-bit LAST pointer: last grantee.
  - 3-bit slot counter, which drives SLOT.
- Reset (IPTRSTN low at an edge):
  - State becomes IDLE.
  - GNT=0000, OWNER=0, SLOT=0, BUSY=0, LAST=3.
  - Reset overrides every other event in the same cycle, including reset during an active grant.
- Arbitration (evaluated in IDLE, and in GAP):
  - Search REQ in the order LAST+1, LAST+2, LAST+3, LAST (mod 4). The first set bit wins.
  - If no REQ bit is set, nothing is selected.
- IDLE:
  - With any REQ bit set at an edge, the winner w is taken. State goes to GRANT, GNT=onehot(w), OWNER=w, LAST=w, SLOT=0.
  - With no REQ bit set, state stays IDLE and all outputs hold their reset values, except that OWNER keeps its last value.
- GRANT:
  - At each edge, if any release condition below holds, state goes to GAP, GNT=0000 and SLOT=0. Otherwise SLOT increments.
  - Release condition (a): SLOT==SLOTLEN-1, i.e. the slot has expired.
  - Release condition (b): DONE[OWNER]=1.
  - Release condition (c): REQ[OWNER]=0, i.e. the requester withdrew.
  - Several release conditions in the same cycle produce a single release and a single GAP.
  - REQ and DONE of non-owners are ignored during GRANT.
- GAP:
  - Lasts exactly one cycle; GNT=0000 and BUSY=1.
  - At the next edge, arbitration runs. A winner gives GRANT exactly as from IDLE; no winner gives IDLE with BUSY=0.
  - A sole requester that holds REQ high is regranted after the gap; the gap is never skipped.
- SLOT arithmetic: 3-bit unsigned counter, never exceeds SLOTLEN-1, no wrap inside a grant. With SLOTLEN=8, SLOT reaches 7 and then releases.
- Invariant: GNT has at most one bit set. GNT nonzero if and only if state is GRANT.

## Timing
- Grant latency: REQ sampled high at edge t in IDLE gives GNT high after edge t, so GNT is visible in cycle t+1.
- Maximum grant length: GNT stays high for exactly SLOTLEN cycles, with SLOT showing 0..SLOTLEN-1.
- Early release: DONE[OWNER] or a dropped REQ[OWNER] sampled at edge t drops GNT after edge t.
- Back-to-back grants have a one-cycle period with GNT=0000 between them.
- Worst-case wait for a continuously requesting line, with all four requesting: 3*(SLOTLEN+1) cycles after its request is first sampled in GAP or IDLE.
- All outputs are registered; there is no combinational path from inputs to outputs.
- BUSY rises one cycle after the winning REQ is sampled, and falls after the GAP cycle when no request is pending.

## Test plan
- Reset check: hold IPTRSTN low 2 cycles with REQ=1111 -> GNT=0000, OWNER=0, SLOT=0, BUSY=0. Release reset -> first grant goes to requester 0 (LAST=3).
- Single requester, SLOTLEN=4, REQ=0100 held:
  - GNT=0100 for 4 cycles with SLOT 0,1,2,3.
  - Then 1 cycle with GNT=0000.
  - Then GNT=0100 again with SLOT back to 0.
- Round-robin, REQ=1111 held, SLOTLEN=2 -> owners in order 0,1,2,3,0. Each grant lasts 2 cycles, with a 1-cycle gap between grants; BUSY stays high throughout.
- Early release and conflicts, SLOTLEN=8:
  - Owner 1 pulses DONE[1] at SLOT=2 -> GNT drops at the next edge.
  - DONE[3] pulsed by a non-owner in the same run -> no effect.
  - DONE[1] and slot expiry in the same cycle -> exactly one gap.
- Withdrawal: owner 2 drops REQ[2] at SLOT=1 with no other requests -> GNT=0000 next cycle, then GAP, then IDLE with BUSY=0. A later REQ=0001 -> GNT=0001 one cycle after it is sampled.
- Reset mid-grant: IPTRSTN low at SLOT=3 of owner 3 -> GNT=0000 and SLOT=0 at the next edge. After reset release with REQ=1000 -> owner 3 is regranted, because LAST was reset to 3 and the search wraps to index 3 last.
